// File: rtl/complex_sq_rr_sched_if.sv
// Handshake bundle between the sample front-ends, the shared complex squarer and the
// downstream accumulator. The design side uses the slave modport.
interface complex_sq_rr_sched_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic                    flush;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_real;
  logic [NREQ*WIDTH-1:0]   req_imag;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [2*WIDTH:0]        res_real;
  logic [2*WIDTH:0]        res_imag;
  logic [IDW-1:0]          res_id;
  logic                    busy;

  modport slave (
    input  flush, req_valid, req_real, req_imag, res_ready,
    output req_ready, res_valid, res_real, res_imag, res_id, busy
  );

  modport master (
    output flush, req_valid, req_real, req_imag, res_ready,
    input  req_ready, res_valid, res_real, res_imag, res_id, busy
  );
endinterface

// File: rtl/complex_sq_rr_sched.sv
// Round-robin scheduler feeding one two-stage complex-squaring pipeline shared by NREQ
// requesters; results come back tagged with the issuing requester's index.
module complex_sq_dp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  output logic [2*WIDTH:0] sq_re,
  output logic [2*WIDTH:0] sq_im
);
  localparam int EW = 2*WIDTH + 1;

  // EW bits hold the worst case 2*(-2^(W-1))^2 = 2^(2W-1) as a positive value
  logic signed [EW-1:0] re_x, im_x;
  assign re_x  = {{(WIDTH+1){a_re[WIDTH-1]}}, a_re};
  assign im_x  = {{(WIDTH+1){a_im[WIDTH-1]}}, a_im};
  assign sq_re = re_x * re_x - im_x * im_x;
  assign sq_im = (re_x * im_x) <<< 1;
endmodule

module complex_sq_rr_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  complex_sq_rr_sched_if.slave bus
);
  localparam int EW     = 2*WIDTH + 1;
  localparam int STAGES = 2;

  logic [NREQ-1:0][WIDTH-1:0] lane_re, lane_im;
  logic [STAGES:1]            vld_pipe;
  logic [IDW-1:0]             ptr, win, id1, id_q;
  logic [WIDTH-1:0]           re1, im1;
  logic [EW-1:0]              sq_re, sq_im, res_re_q, res_im_q;
  logic                       found, adv, accept;
  int                         idx;

  assign lane_re = bus.req_real;
  assign lane_im = bus.req_imag;

  assign adv = !vld_pipe[STAGES] | bus.res_ready;

  // first requesting lane at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // rst gates the grant so nothing is offered while held in reset
  assign accept = found & adv & !bus.flush & rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win] = 1'b1;
  end

  complex_sq_dp #(.WIDTH(WIDTH)) u_dp (
    .a_re  (re1),
    .a_im  (im1),
    .sq_re (sq_re),
    .sq_im (sq_im)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      vld_pipe <= '0;
      re1      <= '0;
      im1      <= '0;
      id1      <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      id_q     <= '0;
    end else begin
      if (accept) ptr <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
      if (bus.flush) begin
        vld_pipe <= '0;
      end else if (adv) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], accept};
        re1      <= lane_re[win];
        im1      <= lane_im[win];
        id1      <= win;
        res_re_q <= sq_re;
        res_im_q <= sq_im;
        id_q     <= id1;
      end
    end
  end

  assign bus.res_valid = vld_pipe[STAGES];
  assign bus.res_real  = res_re_q;
  assign bus.res_imag  = res_im_q;
  assign bus.res_id    = id_q;
  assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_complex_sq_rr_sched.sv
// Directed bench for complex_sq_rr_sched: grants, arithmetic corners, backpressure,
// flush and mid-flight reset, each with hand-computed expectations.
module tb_complex_sq_rr_sched;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = 2*W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  complex_sq_rr_sched_if #(.WIDTH(W), .NREQ(N), .IDW(IDW)) bus ();

  complex_sq_rr_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] r, input logic [W-1:0] m);
    bus.req_real[i*W +: W] = r;
    bus.req_imag[i*W +: W] = m;
  endtask

  task automatic test_reset;
    bus.flush     = 1'b0;
    bus.req_valid = 4'hf;
    bus.res_ready = 1'b1;
    bus.req_real  = '0;
    bus.req_imag  = '0;
    rst = 1'b0;
    tick;
    chk_cnt++;
    if (bus.req_ready !== 4'h0) $display("FAIL reset_req_ready got %b want 0000", bus.req_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_valid_busy got %b%b want 00", bus.res_valid, bus.busy);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.res_real, bus.res_imag, bus.res_id} !== '0)
      $display("FAIL reset_data got %h %h %0d want 0 0 0", bus.res_real, bus.res_imag, bus.res_id);
    else pass_cnt++;
    bus.req_valid = 4'h0;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [EW-1:0] e_re;
    e_re = -7;
    set_op(0, 16'd3, 16'd4);
    bus.req_valid = 4'b0001;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'b0001) $display("FAIL basic_grant got %b want 0001", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = 4'b0000;
    chk_cnt++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL basic_stage1 got valid=%b busy=%b want 0 1", bus.res_valid, bus.busy);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({bus.res_valid, bus.res_real, bus.res_imag, bus.res_id} !== {1'b1, e_re, 33'd24, 2'd0})
      $display("FAIL basic_result got v=%b re=%h im=%h id=%0d want 1 %h 24 0",
               bus.res_valid, bus.res_real, bus.res_imag, bus.res_id, e_re);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if (bus.res_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", bus.res_valid);
    else pass_cnt++;
  endtask

  task automatic test_worst_case;
    set_op(2, 16'sh8000, 16'sh8000);
    bus.req_valid = 4'b0100;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'b0100) $display("FAIL worst_grant got %b want 0100", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = 4'b0000;
    tick;
    chk_cnt++;
    if ({bus.res_valid, bus.res_real, bus.res_imag, bus.res_id} !== {1'b1, 33'd0, 33'h0_8000_0000, 2'd2})
      $display("FAIL worst_result got v=%b re=%h im=%h id=%0d want 1 0 080000000 2",
               bus.res_valid, bus.res_real, bus.res_imag, bus.res_id);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_round_robin;
    logic [N-1:0]  e_rdy;
    logic [IDW-1:0] e_id;
    logic [EW-1:0] e_im;
    // bring ptr back to 0 with a single req3 transaction, then drain
    set_op(3, 16'd1, 16'd1);
    bus.req_valid = 4'b1000;
    tick;
    bus.req_valid = 4'b0000;
    tick; tick; tick;
    for (int i = 0; i < N; i++) set_op(i, W'(i+1), 16'd2);
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 8) ? 4'hf : 4'h0;
      #1;
      if (c < 8) begin
        e_rdy = 4'b0001 << (c % 4);
        chk_cnt++;
        if (bus.req_ready !== e_rdy) $display("FAIL rr_grant c=%0d got %b want %b", c, bus.req_ready, e_rdy);
        else pass_cnt++;
      end
      if (c >= 2) begin
        e_id = IDW'((c-2) % 4);
        e_im = EW'(4 * ((c-2) % 4 + 1));
        chk_cnt++;
        if ({bus.res_valid, bus.res_id, bus.res_imag} !== {1'b1, e_id, e_im})
          $display("FAIL rr_result c=%0d got v=%b id=%0d im=%0d want 1 %0d %0d",
                   c, bus.res_valid, bus.res_id, bus.res_imag, e_id, e_im);
        else pass_cnt++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int sent, recv, cyc, k;
    logic stall_prev;
    logic [2*EW+IDW-1:0] held;
    logic [EW-1:0] e_re, e_im;
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (recv < 6 && cyc < 40) begin
      bus.req_valid = (sent < 6) ? 4'b0010 : 4'b0000;
      set_op(1, W'(sent+1), 16'd1);
      bus.res_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (!bus.res_ready) begin
        chk_cnt++;
        if (bus.req_ready !== 4'h0) $display("FAIL bp_no_grant cyc=%0d got %b want 0000", cyc, bus.req_ready);
        else pass_cnt++;
        if (stall_prev) begin
          chk_cnt++;
          if ({bus.res_real, bus.res_imag, bus.res_id} !== held)
            $display("FAIL bp_hold cyc=%0d got %h want %h", cyc, {bus.res_real, bus.res_imag, bus.res_id}, held);
          else pass_cnt++;
        end
        held = {bus.res_real, bus.res_imag, bus.res_id};
      end
      stall_prev = !bus.res_ready;
      if (bus.res_valid && bus.res_ready) begin
        k = recv + 1;
        e_re = EW'(k*k - 1);
        e_im = EW'(2*k);
        chk_cnt++;
        if ({bus.res_real, bus.res_imag, bus.res_id} !== {e_re, e_im, 2'd1})
          $display("FAIL bp_result n=%0d got re=%0d im=%0d id=%0d want %0d %0d 1",
                   recv, bus.res_real, bus.res_imag, bus.res_id, e_re, e_im);
        else pass_cnt++;
        recv++;
      end
      if (bus.req_ready[1]) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.res_ready = 1'b1;
    chk_cnt++;
    if (recv !== 6 || sent !== 6) $display("FAIL bp_count got recv=%0d sent=%0d want 6 6", recv, sent);
    else pass_cnt++;
    chk_cnt++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL bp_no_dup got valid=%b busy=%b want 0 0", bus.res_valid, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    bus.req_valid = 4'b1000;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'b1000) $display("FAIL flush_pre_grant3 got %b want 1000", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = 4'b0001;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'b0001) $display("FAIL flush_pre_grant0 got %b want 0001", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.flush     = 1'b1;
    bus.req_valid = 4'hf;
    #1;
    chk_cnt++;
    if ({bus.req_ready, bus.res_valid, bus.busy} !== {4'h0, 1'b1, 1'b1})
      $display("FAIL flush_cycle got rdy=%b v=%b busy=%b want 0000 1 1", bus.req_ready, bus.res_valid, bus.busy);
    else pass_cnt++;
    tick;
    bus.flush = 1'b0;
    #1;
    chk_cnt++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL flush_cleared got valid=%b busy=%b want 0 0", bus.res_valid, bus.busy);
    else pass_cnt++;
    chk_cnt++;
    if (bus.req_ready !== 4'b0010) $display("FAIL flush_rotation got %b want 0010", bus.req_ready);
    else pass_cnt++;
    bus.req_valid = 4'h0;
    tick;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < N; i++) set_op(i, 16'd5, 16'd7);
    bus.req_valid = 4'hf;
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'h0) $display("FAIL rst_mid_ready got %b want 0000", bus.req_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.res_valid, bus.busy, bus.res_real, bus.res_imag, bus.res_id} !== '0)
      $display("FAIL rst_mid_outputs got v=%b busy=%b re=%h im=%h id=%0d want all 0",
               bus.res_valid, bus.busy, bus.res_real, bus.res_imag, bus.res_id);
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.req_valid = 4'b1100;
    #1;
    chk_cnt++;
    if (bus.req_ready !== 4'b0100) $display("FAIL rst_mid_first_grant got %b want 0100", bus.req_ready);
    else pass_cnt++;
    bus.req_valid = 4'h0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_worst_case;
    test_round_robin;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
